lfsr_bank_ctrl: RTL and testbench

//  Sequencer and arbiter for the 4-lane 16-bit LFSR bank (lfsr_16x4). Owns the bank's seed/load

---
 rtl/lfsr_ctrl_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/lfsr_bank_ctrl.sv | 135 +++++++++++++
 tb/tb_lfsr_bank_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types, widths and the lock-up fix helper for the LFSR bank controller.
package lfsr_ctrl_pkg;

    localparam int unsigned LANE_W = 16;
    localparam int unsigned NLANES = 4;
    localparam int unsigned BANK_W = LANE_W * NLANES;

    localparam logic [LANE_W-1:0] LOCKUP     = 16'hFFFF;
    localparam logic [LANE_W-1:0] LOCKUP_FIX = 16'hFFFE;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    // An all-ones lane would freeze an XNOR LFSR, so nudge it off the lock-up state.
    function automatic logic [BANK_W-1:0] fix_seed(input logic [BANK_W-1:0] seed);
        logic [BANK_W-1:0] fixed;
        fixed = seed;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (seed[i*LANE_W +: LANE_W] == LOCKUP) begin
                fixed[i*LANE_W +: LANE_W] = LOCKUP_FIX;
            end
        end
        return fixed;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin : p_search
        int unsigned cand;
        logic [N-1:0] req_rot;
        cand     = 0;
        req_rot  = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand    = (32'(i_ptr) + off) % N;
            req_rot = i_req >> cand;
            if (!o_any && req_rot[0]) begin
                o_any    = 1'b1;
                o_idx    = IDX_W'(cand);
                o_onehot = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/lfsr_bank_ctrl.sv
// Seeds and warms up the 4-lane LFSR bank, then round-robins its lanes to requesters.
module lfsr_bank_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned       NREQ            = 4,
    parameter int unsigned       WARMUP          = 16,
    parameter int unsigned       RESEED_INTERVAL = 1024,
    parameter logic [BANK_W-1:0] SEED_DEFAULT    = 64'hACE1_1D2B_5A5A_0F0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BANK_W-1:0] seed_in,
    input  logic              seed_wr,
    output logic [BANK_W-1:0] bank_seed,
    output logic              bank_load,
    input  logic [BANK_W-1:0] bank_q,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic              rnd_valid,
    output logic [LANE_W-1:0] rnd_data,
    output logic              ready
);

    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WCNT_W = $clog2(WARMUP + 1);
    localparam int unsigned GCNT_W = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;

    state_t              r_state;
    logic [BANK_W-1:0]   r_seed;
    logic                r_bank_load;
    logic                r_ready;
    logic [NREQ-1:0]     r_gnt;
    logic                r_valid;
    logic [LANE_W-1:0]   r_data;
    logic [IDX_W-1:0]    r_ptr;
    logic [WCNT_W-1:0]   r_warm_cnt;
    logic [GCNT_W-1:0]   r_gnt_cnt;

    state_t              w_state_nxt;
    logic [BANK_W-1:0]   w_seed_nxt;
    logic                w_grant;
    logic [NREQ-1:0]     w_onehot;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic [1:0]          w_lane;
    logic [LANE_W-1:0]   w_word;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // Requester i always reads lane i mod 4.
    assign w_lane = 2'(32'(w_idx) % NLANES);
    assign w_word = LANE_W'(bank_q >> (LANE_W * 32'(w_lane)));

    always_comb begin
        w_state_nxt = r_state;
        w_seed_nxt  = r_seed;
        w_grant     = 1'b0;
        case (r_state)
            LOAD: w_state_nxt = WARM;
            WARM: begin
                if (r_warm_cnt == WCNT_W'(WARMUP - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_grant = w_any;
                if (w_grant && (RESEED_INTERVAL != 0) &&
                    (r_gnt_cnt == GCNT_W'(RESEED_INTERVAL - 1))) begin
                    w_seed_nxt  = fix_seed(bank_q);
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
        // Software seed write overrides everything, including the grant in flight.
        if (seed_wr) begin
            w_grant     = 1'b0;
            w_seed_nxt  = fix_seed(seed_in);
            w_state_nxt = LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= LOAD;
            r_seed      <= fix_seed(SEED_DEFAULT);
            r_bank_load <= 1'b1;
            r_ready     <= 1'b0;
            r_gnt       <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_ptr       <= IDX_W'(NREQ - 1);
            r_warm_cnt  <= '0;
            r_gnt_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_seed      <= w_seed_nxt;
            r_bank_load <= (w_state_nxt == LOAD);
            r_ready     <= (w_state_nxt == RUN);
            r_valid     <= w_grant;
            r_gnt       <= w_grant ? w_onehot : '0;
            if (w_grant) begin
                r_data <= w_word;
                r_ptr  <= w_idx;
            end
            if (r_state == WARM) begin
                r_warm_cnt <= r_warm_cnt + WCNT_W'(1);
            end else begin
                r_warm_cnt <= '0;
            end
            if (w_state_nxt == LOAD) begin
                r_gnt_cnt <= '0;
            end else if (w_grant) begin
                r_gnt_cnt <= r_gnt_cnt + GCNT_W'(1);
            end
        end
    end

    assign bank_seed = r_seed;
    assign bank_load = r_bank_load;
    assign ready     = r_ready;
    assign gnt       = r_gnt;
    assign rnd_valid = r_valid;
    assign rnd_data  = r_data;

endmodule

// File: tb/tb_lfsr_bank_ctrl.sv
// Randomized bench for lfsr_bank_ctrl: two configurations checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_lfsr_bank_ctrl;

    localparam int NA = 4, WA = 16, RA = 1024;
    localparam int NB = 3, WB = 3,  RB = 4;
    localparam logic [63:0] SEED_DEF = 64'hACE1_1D2B_5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] seed_in = '0;
    logic        seed_wr = 1'b0;
    logic [63:0] bank_q = '0;
    logic [3:0]  req = '0;

    logic [63:0] bank_seed_a, bank_seed_b;
    logic        bank_load_a, bank_load_b;
    logic [3:0]  gnt_a;
    logic [2:0]  gnt_b;
    logic        rnd_valid_a, rnd_valid_b;
    logic [15:0] rnd_data_a, rnd_data_b;
    logic        ready_a, ready_b;

    always #5 clk = ~clk;

    lfsr_bank_ctrl #(.NREQ(NA), .WARMUP(WA), .RESEED_INTERVAL(RA)) u_dut_a (
        .clk(clk), .reset(rst_n), .seed_in(seed_in), .seed_wr(seed_wr),
        .bank_seed(bank_seed_a), .bank_load(bank_load_a), .bank_q(bank_q),
        .req(req), .gnt(gnt_a), .rnd_valid(rnd_valid_a), .rnd_data(rnd_data_a),
        .ready(ready_a)
    );

    lfsr_bank_ctrl #(.NREQ(NB), .WARMUP(WB), .RESEED_INTERVAL(RB)) u_dut_b (
        .clk(clk), .reset(rst_n), .seed_in(seed_in), .seed_wr(seed_wr),
        .bank_seed(bank_seed_b), .bank_load(bank_load_b), .bank_q(bank_q),
        .req(req[2:0]), .gnt(gnt_b), .rnd_valid(rnd_valid_b), .rnd_data(rnd_data_b),
        .ready(ready_b)
    );

    // age: cycles since the last load (0 = load cycle, 1..WARMUP = warm-up, beyond = running)
    typedef struct {
        int          age;
        logic [63:0] seed;
        int          ptr;
        int          gcnt;
        logic [7:0]  gnt;
        logic        valid;
        logic [15:0] data;
    } mdl_t;

    mdl_t ma, mb;
    int n_chk = 0;
    int n_err = 0;
    logic [63:0] bq_last;
    bit rand_bq = 1'b1;
    logic [3:0] exp_g [5];

    function automatic logic [63:0] fix64(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        for (int l = 0; l < 4; l++)
            if (s[l*16 +: 16] == 16'hFFFF) r[l*16 +: 16] = 16'hFFFE;
        return r;
    endfunction

    function automatic mdl_t mdl_init(input int nreq);
        mdl_t m;
        m.age = 0; m.seed = fix64(SEED_DEF); m.ptr = nreq - 1; m.gcnt = 0;
        m.gnt = '0; m.valid = 1'b0; m.data = '0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int nreq, input int warm, input int ri,
                                      input logic sw, input logic [63:0] sin,
                                      input logic [7:0] rq, input logic [63:0] bq);
        mdl_t n;
        logic [7:0] r;
        int w;
        n = m;
        n.gnt = '0;
        n.valid = 1'b0;
        r = rq & 8'((1 << nreq) - 1);
        w = 0;
        if (sw) begin
            n.seed = fix64(sin); n.age = 0; n.gcnt = 0;
        end else if (m.age <= warm) begin
            n.age = m.age + 1;
        end else if (r != 0) begin
            for (int off = 1; off <= nreq; off++) begin
                w = (m.ptr + off) % nreq;
                if (r[w]) break;
            end
            n.gnt = 8'(1) << w;
            n.valid = 1'b1;
            n.data = bq[(w % 4)*16 +: 16];
            n.ptr = w;
            n.gcnt = m.gcnt + 1;
            if (ri != 0 && n.gcnt == ri) begin
                n.seed = fix64(bq); n.age = 0; n.gcnt = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = mdl_init(NA);
            mb = mdl_init(NB);
        end else begin
            ma = mdl_step(ma, NA, WA, RA, seed_wr, seed_in, {4'b0, req}, bank_q);
            mb = mdl_step(mb, NB, WB, RB, seed_wr, seed_in, {5'b0, req[2:0]}, bank_q);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("a.bank_seed", bank_seed_a, ma.seed);
        chk("a.bank_load", 64'(bank_load_a), 64'(ma.age == 0));
        chk("a.ready", 64'(ready_a), 64'(ma.age > WA));
        chk("a.gnt", 64'(gnt_a), 64'(ma.gnt));
        chk("a.rnd_valid", 64'(rnd_valid_a), 64'(ma.valid));
        if (ma.valid) chk("a.rnd_data", 64'(rnd_data_a), 64'(ma.data));
        chk("b.bank_seed", bank_seed_b, mb.seed);
        chk("b.bank_load", 64'(bank_load_b), 64'(mb.age == 0));
        chk("b.ready", 64'(ready_b), 64'(mb.age > WB));
        chk("b.gnt", 64'(gnt_b), 64'(mb.gnt));
        chk("b.rnd_valid", 64'(rnd_valid_b), 64'(mb.valid));
        if (mb.valid) chk("b.rnd_data", 64'(rnd_data_b), 64'(mb.data));
    endtask

    function automatic logic [63:0] rnd_word();
        logic [63:0] v;
        for (int l = 0; l < 4; l++)
            v[l*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        return v;
    endfunction

    task automatic cyc();
        @(negedge clk);
        compare_all();
        bq_last = bank_q;
        if (rand_bq) bank_q = rnd_word();
    endtask

    initial begin
        int n, low, ng;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        bank_q = rnd_word();
        repeat (3) cyc();

        // Reset release, default seed, warm-up length
        rst_n = 1'b1;
        #1;
        chk("t1.load_at_release", 64'(bank_load_a), 64'd1);
        chk("t1.default_seed", bank_seed_a, 64'hACE1_1D2B_5A5A_0F0F);
        chk("t1.ready_at_release", 64'(ready_a), 64'd0);
        n = 0;
        while (ready_a !== 1'b1 && n < 40) begin
            cyc();
            n++;
            if (n == 1) chk("t1.load_one_cycle", 64'(bank_load_a), 64'd0);
        end
        chk("t1.ready_latency", 64'(n), 64'd17);

        // All four requesting: strict rotation from requester 0
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t3.gnt_rotation", 64'(gnt_a), 64'(exp_g[k]));
            chk("t3.lane_data", 64'(rnd_data_a), 64'(bq_last[(k % 4)*16 +: 16]));
        end

        // Sole requester back-to-back, then interrupted by a software seed
        req = 4'b0100;
        repeat (2) begin
            cyc();
            chk("t4.sole_gnt", 64'(gnt_a), 64'(4'b0100));
        end
        seed_in = 64'hFFFF_0001_FFFF_0002;
        seed_wr = 1'b1;
        cyc();
        seed_wr = 1'b0;
        chk("t4.no_gnt_after_wr", 64'(gnt_a), 64'd0);
        chk("t4.no_valid_after_wr", 64'(rnd_valid_a), 64'd0);
        chk("t4.load_after_wr", 64'(bank_load_a), 64'd1);
        chk("t2.fixed_seed", bank_seed_a, 64'hFFFE_0001_FFFE_0002);
        low = 1;
        while (ready_a !== 1'b1 && low < 40) begin
            cyc();
            if (ready_a !== 1'b1) low++;
        end
        chk("t4.ready_low_cycles", 64'(low), 64'd17);
        chk("t4.no_gnt_at_ready", 64'(gnt_a), 64'd0);
        cyc();
        chk("t4.gnt_resumes", 64'(gnt_a), 64'(4'b0100));

        // Auto-reseed after four grants on the small configuration
        seed_in = rnd_word();
        seed_wr = 1'b1;
        cyc();
        seed_wr = 1'b0;
        req = 4'b0001;
        rand_bq = 1'b0;
        bank_q = 64'h1111_FFFF_3333_4444;
        ng = 0; n = 0;
        while (ng < 4 && n < 40) begin
            cyc();
            n++;
            if (gnt_b == 3'b001) ng++;
        end
        chk("t5.grant_count", 64'(ng), 64'd4);
        chk("t5.reseed_load", 64'(bank_load_b), 64'd1);
        chk("t5.reseed_seed", bank_seed_b, 64'h1111_FFFE_3333_4444);
        chk("t5.fourth_data", 64'(rnd_data_b), 64'h4444);
        cyc();
        chk("t5.no_gnt_in_load", 64'(gnt_b), 64'd0);
        rand_bq = 1'b1;

        // Asynchronous reset during warm-up
        seed_wr = 1'b1;
        cyc();
        seed_wr = 1'b0;
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6.warm_ready", 64'(ready_a), 64'd0);
        chk("t6.warm_load", 64'(bank_load_a), 64'd1);
        chk("t6.warm_seed", bank_seed_a, SEED_DEF);
        cyc();
        rst_n = 1'b1;

        // Asynchronous reset while a grant is showing
        req = 4'b1111;
        n = 0;
        while (gnt_a == 4'b0000 && n < 40) begin
            cyc();
            n++;
        end
        chk("t6.grant_seen", 64'(gnt_a != 4'b0000), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.grant_dropped", 64'(gnt_a), 64'd0);
        chk("t6.valid_dropped", 64'(rnd_valid_a), 64'd0);
        chk("t6.data_cleared", 64'(rnd_data_a), 64'd0);
        chk("t6.ready_dropped", 64'(ready_a), 64'd0);
        chk("t6.load_asserted", 64'(bank_load_a), 64'd1);
        chk("t6.b_grant_dropped", 64'(gnt_b), 64'd0);
        cyc();
        rst_n = 1'b1;

        // Random traffic: held requests, occasional seed writes and resets
        for (int i = 0; i < 2000; i++) begin
            cyc();
            rst_n = 1'b1;
            req = (req & ~gnt_a) | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            seed_wr = ($urandom_range(0, 99) == 0);
            seed_in = rnd_word();
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #1 compare_all();
            end
        end
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
